// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential unsigned shift-and-add multiplier with ripple-carry adder
//
// shift_add_mult: unsigned WIDTH x WIDTH multiplier producing a 2*WIDTH product,
// one add/shift step per clock, valid/ready handshake on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (a_in multiplicand, b_in multiplier)
//   out_valid/out_ready : product handshake (product held until accepted)
//   busy                : high while the multiply steps are running
// Optional: define SHIFT_ADD_MULT_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero.
//
// adder: WIDTH-bit ripple-carry adder, s = a + b with carry-out c.

module adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  always_comb begin
    logic cr;
    cr = 1'b0;
    s  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ cr;
      cr   = (a[i] & b[i]) | (cr & (a[i] ^ b[i]));
    end
    c = cr;
  end

endmodule

module shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p_reg;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] p_step;

  // Upper half of P accumulates; the multiplier bits drain out of the lower half.
  adder #(.WIDTH(WIDTH)) u_adder (
    .a (p_reg[2*WIDTH-1:WIDTH]),
    .b (mcand),
    .s (sum),
    .c (carry)
  );

  // Carry lands in the MSB so nothing is lost when the sum shifts right.
  always_comb begin
    p_step = {1'b0, p_reg[2*WIDTH-1:1]};
    if (p_reg[0]) begin
      p_step = {carry, sum, p_reg[WIDTH-1:1]};
    end
  end

`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
  logic [2*WIDTH-1:0] low_mask;
  logic               early_hit;
  logic [2*WIDTH-1:0] p_early;

  // Low 'count' bits of P are the multiplier bits still to be consumed.
  always_comb begin
    low_mask  = ~({(2*WIDTH){1'b1}} << count);
    early_hit = ((p_reg & low_mask) == '0);
    p_early   = p_reg >> count;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mcand     <= '0;
      p_reg     <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= a_in;
            p_reg    <= {{WIDTH{1'b0}}, b_in};
            count    <= CW'(WIDTH);
            state    <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        S_RUN: begin
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
          if (early_hit) begin
            p_reg     <= p_early;
            count     <= '0;
            product   <= p_early;
            state     <= S_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else
`endif
          begin
            p_reg <= p_step;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              product   <= p_step;
              state     <= S_DONE;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // in_ready only rises once IDLE is reached, so no same-cycle re-accept.
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - directed self-checking bench for shift_add_mult

module tb_shift_add_mult;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int total;
  int bad;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One full operation: accept, measure latency/busy, optional backpressure, handshake.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_prod, input int runs_plain, input int runs_early,
                        input int hold);
    int lat;
    int busy_cnt;
    int waited;
    int exp_runs;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    exp_runs = runs_early;
`else
    exp_runs = runs_plain;
`endif
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_ready_wait"}, 32'(waited < 50), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_in     = ~a;
    b_in     = ~b;
    lat      = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_runs + 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_runs));
    check({tag, "_product"}, 32'(product), 32'(exp_prod));
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_product"}, 32'(product), 32'(exp_prod));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_post_product"}, 32'(product), 32'(exp_prod));
  endtask

  logic [W-1:0] pa [4];
  logic [W-1:0] pb [4];
  int           pe [4];

  initial begin
    int idx;
    int oi;
    int cyc;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;

    //      tag      a        b        prod plain early hold
    run_op("m11x9",  4'd11,  4'd9,    99,  4,    4,    0);
    run_op("m15x15", 4'd15,  4'd15,   225, 4,    4,    0);
    run_op("m0x13",  4'd0,   4'd13,   0,   4,    4,    0);
    run_op("m5x0",   4'd5,   4'd0,    0,   4,    1,    0);
    run_op("m9x1",   4'd9,   4'd1,    9,   4,    2,    0);
    run_op("m7x8",   4'd7,   4'd8,    56,  4,    4,    0);
    run_op("bp6x7",  4'd6,   4'd7,    42,  4,    4,    10);

    // Reset mid-operation
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 4'd7;
    b_in     = 4'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("m3x5", 4'd3, 4'd5, 15, 4, 4, 0);

    // Back-to-back with in_valid held high
    pa[0] = 4'd2;  pb[0] = 4'd3;  pe[0] = 6;
    pa[1] = 4'd13; pb[1] = 4'd11; pe[1] = 143;
    pa[2] = 4'd15; pb[2] = 4'd1;  pe[2] = 15;
    pa[3] = 4'd8;  pb[3] = 4'd12; pe[3] = 96;
    idx       = 0;
    oi        = 0;
    out_ready = 1'b1;
    for (cyc = 0; cyc < 120; cyc++) begin
      @(negedge clk);
      if (idx < 4) begin
        a_in = pa[idx];
        b_in = pb[idx];
      end
      in_valid = (idx < 4);
      if (in_ready && out_valid) check("b2b_ready_and_valid", 32'd1, 32'd0);
      if (out_valid) begin
        if (oi < 4) check("b2b_product", 32'(product), 32'(pe[oi]));
        oi++;
      end
      if (in_ready && in_valid) idx++;
      if (idx == 4 && oi == 4 && !busy && !out_valid) cyc = 200;
    end
    in_valid = 1'b0;
    check("b2b_accepted", 32'(idx), 32'd4);
    check("b2b_outputs", 32'(oi), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
